// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment display path.
// Segment constants are active-low, bit order ABCDEFG (bit 6 = A, bit 0 = G),
// and are the same values the encoder side drives onto the display bus.
package sevenseg_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } capture_state_t;

endpackage

// File: rtl/sevenseg_capture_if.sv
// Display bus as seen by the capture block.
//   seg_n[6:0]   active-low segments ABCDEFG
//   an_n[3:0]    active-low digit anodes
//   value[15:0]  last completed frame, digit i in value[4i+3:4i]
//   frame_valid  one-cycle pulse when value/frame_err update
//   frame_err    last frame held an undecodable pattern
//   stale        one-cycle pulse when a partial frame times out
// master = display driver / bench side, slave = capture block.
interface sevenseg_capture_if;
    import sevenseg_pkg::*;

    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   an_n;
    logic [4*DIGITS-1:0] value;
    logic                frame_valid;
    logic                frame_err;
    logic                stale;

    modport master (
        output seg_n, an_n,
        input  value, frame_valid, frame_err, stale
    );

    modport slave (
        input  seg_n, an_n,
        output value, frame_valid, frame_err, stale
    );

endinterface

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment to BCD decoder.
//   seg_n[6:0]  active-low pattern ABCDEFG
//   bcd[3:0]    decoded digit, 4'hF when the pattern is not a digit
//   invalid     high for any pattern outside the 0..9 table (blank included)
module seg_to_bcd
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] bcd,
    output logic       invalid
);

    always_comb begin
        bcd     = 4'hF;
        invalid = 1'b0;
        case (seg_n)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Reconstructs the BCD value shown on a multiplexed 4-digit display bus.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    sevenseg_capture_if.slave: seg_n/an_n in, value/frame_valid/
//          frame_err/stale out
// A digit is committed once the same (digit, pattern) pair has been seen for
// STABLE_CYCLES consecutive cycles; a frame completes when all four digits
// have committed. A partial frame with no commit for TIMEOUT cycles is dropped.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   BLANK  | no single anode active; waiting for a digit to appear
//   SETTLE | counting identical (digit, pattern) cycles toward a commit
//   HELD   | current dwell already committed; ignore until it changes
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    sevenseg_capture_if.slave  bus
);

    localparam int              DIG_W     = $clog2(DIGITS);
    localparam int              TMR_W     = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [8:0]      STABLE_TH = 9'(STABLE_CYCLES);

    capture_state_t            state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [DIG_W-1:0]          prev_dig_q, prev_dig_d;
    logic [6:0]                prev_pat_q, prev_pat_d;
    logic [DIGITS-1:0][3:0]    digit_q, digit_d;
    logic [DIGITS-1:0]         seen_q, seen_d;
    logic [DIGITS-1:0]         bad_q, bad_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [4*DIGITS-1:0]       value_q, value_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      stale_q, stale_d;

    logic [DIGITS-1:0]         an_act;
    logic                      qual;
    logic [DIG_W-1:0]          cur_dig;
    logic                      same;
    logic                      new_dwell;
    logic                      commit;
    logic [3:0]                dec_bcd;
    logic                      dec_inv;

    seg_to_bcd u_dec (
        .seg_n   (bus.seg_n),
        .bcd     (dec_bcd),
        .invalid (dec_inv)
    );

    // Anode qualification: exactly one active anode selects a digit.
    always_comb begin
        an_act  = ~bus.an_n;
        qual    = $onehot(an_act);
        cur_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_act[i]) cur_dig = DIG_W'(i);
        end
        same       = (cur_dig == prev_dig_q) && (bus.seg_n == prev_pat_q);
        prev_dig_d = cur_dig;
        prev_pat_d = bus.seg_n;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        new_dwell = 1'b0;
        case (state_q)
            BLANK: begin
                if (qual) new_dwell = 1'b1;
            end
            SETTLE: begin
                if (!qual) begin
                    state_d = BLANK;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    new_dwell = 1'b1;
                end else if ({1'b0, cnt_q} + 9'd1 >= STABLE_TH) begin
                    commit  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!qual) begin
                    state_d = BLANK;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    new_dwell = 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase

        // The first cycle of a dwell already counts as one; with a threshold
        // of one it is also the committing cycle.
        if (new_dwell) begin
            cnt_d = 8'd1;
            if (STABLE_CYCLES == 1) begin
                commit  = 1'b1;
                state_d = HELD;
            end else begin
                state_d = SETTLE;
            end
        end
    end

    // Frame assembly and partial-frame timeout. The timer is a down-counter
    // reloaded on every commit; reaching zero with digits pending discards them.
    always_comb begin
        digit_d       = digit_q;
        seen_d        = seen_q;
        bad_d         = bad_q;
        tmr_d         = tmr_q;
        value_d       = value_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;
        stale_d       = 1'b0;

        if (commit) begin
            digit_d[cur_dig] = dec_bcd;
            bad_d[cur_dig]   = dec_inv;
            seen_d[cur_dig]  = 1'b1;
            tmr_d            = TMR_LOAD;
            if (&seen_d) begin
                value_d       = digit_d;
                frame_err_d   = |bad_d;
                frame_valid_d = 1'b1;
                seen_d        = '0;
                bad_d         = '0;
            end
        end else if (seen_q != '0) begin
            if (tmr_q == '0) begin
                seen_d  = '0;
                bad_d   = '0;
                stale_d = 1'b1;
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BLANK;
            cnt_q         <= 8'd0;
            prev_dig_q    <= '0;
            prev_pat_q    <= '0;
            digit_q       <= '0;
            seen_q        <= '0;
            bad_q         <= '0;
            tmr_q         <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_dig_q    <= prev_dig_d;
            prev_pat_q    <= prev_pat_d;
            digit_q       <= digit_d;
            seen_q        <= seen_d;
            bad_q         <= bad_d;
            tmr_q         <= tmr_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            stale_q       <= stale_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scenarios plus randomized display
// traffic, all checked every cycle against a dwell/frame reference model.
module tb_sevenseg_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sevenseg_capture_if bus ();

    sevenseg_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT       (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] t_seg;
    logic [3:0] t_bcd;
    logic       t_inv;

    seg_to_bcd u_dec_chk (
        .seg_n   (t_seg),
        .bcd     (t_bcd),
        .invalid (t_inv)
    );

    int vectors    = 0;
    int miscompares = 0;
    int fv_total   = 0;
    int stale_total = 0;
    bit cmp_on     = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0001100};

    // reference model state
    int         run_len = 0;
    int         pd = 0;
    logic [6:0] pp = '0;
    logic [3:0] m_dig [4];
    bit         m_seen [4];
    bit         m_bad [4];
    int         idle = 0;
    logic [15:0] m_value = '0;
    bit         m_fv = 1'b0, m_ferr = 1'b0, m_stale = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_dec(input logic [6:0] p, output logic [3:0] v, output bit inv);
        v   = 4'hF;
        inv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (seg_tbl[i] == p) begin
                v   = 4'(i);
                inv = 1'b0;
            end
        end
    endfunction

    // Advance the model by one clock edge using the inputs of the cycle ending now.
    task automatic model_edge();
        int         ones;
        int         d;
        bit         commit;
        bit         all_seen;
        logic [3:0] v;
        bit         inv;
        m_fv    = 1'b0;
        m_stale = 1'b0;
        if (reset) begin
            run_len = 0;
            idle    = 0;
            m_value = '0;
            m_ferr  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_dig[i] = '0; m_seen[i] = 1'b0; m_bad[i] = 1'b0;
            end
            return;
        end
        ones = 0;
        d    = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.an_n[i] == 1'b0) begin
                ones++;
                d = i;
            end
        end
        if (ones != 1) begin
            run_len = 0;
        end else if (run_len > 0 && d == pd && bus.seg_n == pp) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_len = 1;
        end
        pd = d;
        pp = bus.seg_n;
        commit = (ones == 1) && (run_len == STABLE);
        if (commit) begin
            ref_dec(bus.seg_n, v, inv);
            m_dig[d]  = v;
            m_bad[d]  = inv;
            m_seen[d] = 1'b1;
            idle      = 0;
            all_seen  = 1'b1;
            for (int i = 0; i < 4; i++) if (!m_seen[i]) all_seen = 1'b0;
            if (all_seen) begin
                m_ferr = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    m_value[4*i +: 4] = m_dig[i];
                    if (m_bad[i]) m_ferr = 1'b1;
                    m_seen[i] = 1'b0;
                    m_bad[i]  = 1'b0;
                end
                m_fv = 1'b1;
            end
        end else if (m_seen[0] || m_seen[1] || m_seen[2] || m_seen[3]) begin
            idle++;
            if (idle == TMO) begin
                for (int i = 0; i < 4; i++) begin
                    m_seen[i] = 1'b0; m_bad[i] = 1'b0;
                end
                idle    = 0;
                m_stale = 1'b1;
            end
        end
    endtask

    // One clock cycle: apply inputs, compare outputs mid-cycle, step the model.
    task automatic step(input logic [3:0] an, input logic [6:0] seg, input bit rst);
        reset     = rst;
        bus.an_n  = an;
        bus.seg_n = seg;
        @(negedge clk);
        if (cmp_on) begin
            check("value", bus.value, m_value);
            check("frame_valid", bus.frame_valid, m_fv);
            check("frame_err", bus.frame_err, m_ferr);
            check("stale", bus.stale, m_stale);
        end
        if (bus.frame_valid === 1'b1) fv_total++;
        if (bus.stale === 1'b1) stale_total++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        logic [3:0] a;
        a = ~(4'b0001 << d);
        repeat (n) step(a, p, 1'b0);
    endtask

    task automatic blank(input int n);
        repeat (n) step(4'hF, 7'h7F, 1'b0);
    endtask

    task automatic frame(input int v0, input int v1, input int v2, input int v3);
        show(0, seg_tbl[v0], 6); blank(2);
        show(1, seg_tbl[v1], 6); blank(2);
        show(2, seg_tbl[v2], 6); blank(2);
        show(3, seg_tbl[v3], 6); blank(2);
    endtask

    initial begin
        int         f0;
        logic [3:0] ev;
        bit         einv;
        int         dwell;
        int         sel;
        logic [3:0] ra;
        logic [6:0] rs;
        bit         rr;

        reset     = 1'b1;
        bus.an_n  = 4'hF;
        bus.seg_n = 7'h7F;

        // decoder, all 128 patterns
        for (int i = 0; i < 128; i++) begin
            t_seg = 7'(i);
            #1;
            ref_dec(t_seg, ev, einv);
            check("dec_bcd", t_bcd, ev);
            check("dec_invalid", t_inv, einv);
        end
        t_seg = 7'b0000110; #1;
        check("dec_3_bcd", t_bcd, 4'd3);
        check("dec_3_inv", t_inv, 1'b0);
        t_seg = 7'b1111111; #1;
        check("dec_blank_bcd", t_bcd, 4'hF);
        check("dec_blank_inv", t_inv, 1'b1);

        // reset
        step(4'hF, 7'h7F, 1'b1);
        cmp_on = 1'b1;
        step(4'hF, 7'h7F, 1'b1);
        check("rst_value", bus.value, 16'h0000);
        check("rst_fv", bus.frame_valid, 1'b0);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_stale", bus.stale, 1'b0);
        blank(2);

        // normal frame 5,7,0,2 with pulse timing on digit 3
        f0 = fv_total;
        show(0, seg_tbl[5], 6); blank(2);
        show(1, seg_tbl[7], 6); blank(2);
        show(2, seg_tbl[0], 6); blank(2);
        for (int k = 1; k <= 6; k++) begin
            show(3, seg_tbl[2], 1);
            if (k == 3) check("fv_early", bus.frame_valid, 1'b0);
            if (k == 4) check("fv_timing", bus.frame_valid, 1'b1);
            if (k == 5) check("fv_single", bus.frame_valid, 1'b0);
        end
        blank(2);
        check("normal_value", bus.value, 16'h2075);
        check("normal_ferr", bus.frame_err, 1'b0);
        check("normal_fv_count", fv_total - f0, 1);

        // glitch on digit 1: 8 for 3 cycles must not complete the frame
        show(0, seg_tbl[6], 6); blank(2);
        show(2, seg_tbl[3], 6); blank(2);
        show(3, seg_tbl[4], 6); blank(2);
        f0 = fv_total;
        show(1, 7'b0000000, 3);
        show(1, 7'b1001111, 3);
        check("glitch_no_commit", fv_total - f0, 0);
        show(1, 7'b1001111, 1);
        check("glitch_fv", bus.frame_valid, 1'b1);
        check("glitch_value", bus.value, 16'h4316);
        blank(2);

        // undecodable pattern on digit 2
        show(0, seg_tbl[9], 6); blank(2);
        show(1, seg_tbl[9], 6); blank(2);
        show(2, 7'b1111111, 8); blank(2);
        show(3, seg_tbl[9], 6); blank(2);
        check("invalid_value", bus.value, 16'h9F99);
        check("invalid_ferr", bus.frame_err, 1'b1);
        frame(1, 2, 3, 4);
        check("recover_value", bus.value, 16'h4321);
        check("recover_ferr", bus.frame_err, 1'b0);

        // timeout after two commits
        f0 = stale_total;
        show(0, seg_tbl[7], 6); blank(2);
        show(1, seg_tbl[8], 4);
        for (int k = 1; k <= 16; k++) begin
            blank(1);
            check("stale_timing", bus.stale, (k == 16) ? 1'b1 : 1'b0);
        end
        blank(1);
        check("stale_single", bus.stale, 1'b0);
        check("stale_count", stale_total - f0, 1);
        check("stale_value_held", bus.value, 16'h4321);
        check("stale_ferr_held", bus.frame_err, 1'b0);
        frame(5, 6, 7, 8);
        check("post_stale_value", bus.value, 16'h8765);

        // reset in the middle of a frame
        show(0, seg_tbl[1], 6); blank(2);
        show(1, seg_tbl[2], 6); blank(2);
        show(2, seg_tbl[3], 6); blank(2);
        step(4'hF, 7'h7F, 1'b1);
        check("midrst_value", bus.value, 16'h0000);
        check("midrst_ferr", bus.frame_err, 1'b0);
        check("midrst_fv", bus.frame_valid, 1'b0);
        check("midrst_stale", bus.stale, 1'b0);
        f0 = fv_total;
        show(3, seg_tbl[4], 6); blank(4);
        check("midrst_no_frame", fv_total - f0, 0);
        check("midrst_value_after", bus.value, 16'h0000);

        // randomized display traffic
        dwell = 0;
        ra    = 4'hF;
        rs    = 7'h7F;
        for (int c = 0; c < 3000; c++) begin
            if (dwell == 0) begin
                dwell = int'($urandom_range(1, 8));
                sel   = int'($urandom_range(0, 9));
                if (sel == 0)      ra = 4'hF;
                else if (sel == 1) ra = 4'($urandom_range(0, 15));
                else               ra = ~(4'b0001 << $urandom_range(0, 3));
                if ($urandom_range(0, 9) < 8) rs = seg_tbl[$urandom_range(0, 9)];
                else                          rs = 7'($urandom_range(0, 127));
            end
            dwell--;
            rr = ($urandom_range(0, 599) == 0);
            step(ra, rs, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
